mdc_stream_sink: RTL and testbench
==================================

# mdc_stream_sink

Consumer-side endpoint for the multi-dataflow network's `data`/`wr`/`full` output stream. It accepts words written by the network's output port and buffers them in a small FIFO. It re-emits them as a valid/ready stream toward the host-side DMA or HWPE streamer, framing each transfer with a programmed beat count and a `last` marker. One transfer is armed per `start` pulse; `done` pulses when the final beat has been handed off.

## Interface
Parameters:
- DATA_W, 32, stream word width
- DEPTH, 16, FIFO depth in words, power of two, ≥2
- LEN_W, 16, width of the transfer-length field and counters

Ports:
- clock  in  1  system clock, all logic rising-edge
- reset  in  1  asynchronous, active-high; clears all state
- in_data  in  DATA_W  word from network output stream
- in_wr  in  1  write strobe; a word is accepted when in_wr=1 and in_full=0
- in_full  out  1  back-pressure to network
- out_data  out  DATA_W  emitted word
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accept; beat transfers when out_valid & out_ready
- out_last  out  1  high with the final beat of a transfer
- cfg_len  in  LEN_W  beats in the next transfer, sampled on start
- start  in  1  single-cycle arm pulse, honoured only in IDLE
- busy  out  1  transfer in progress (RUN or DONE)
- done  out  1  single-cycle completion pulse
- overflow  out  1  sticky; a write was attempted while in_full=1 in RUN
- level  out  $clog2(DEPTH)+1  current FIFO occupancy

## Operation
- Reset values: in_full=1, out_valid=0, out_last=0, busy=0, done=0, overflow=0, level=0, out_data=0; state IDLE; FIFO empty; counters 0.
- FSM:
  - IDLE: in_full=1, no writes accepted.
    - start & cfg_len≠0: latch len, clear wr_cnt/rd_cnt and overflow, go to RUN.
    - start & cfg_len=0: go to DONE without entering RUN; done pulses next cycle.
  - RUN:
    - in_full = (level==DEPTH) | (wr_cnt==len).
    - Accepted write: push, wr_cnt+1.
    - Beat handshake: pop, rd_cnt+1.
    - out_last = out_valid & (rd_cnt==len-1).
    - Handshake of the last beat: go to DONE.
  - DONE: done=1 for exactly one cycle, in_full=1, then IDLE.
- Write gating: words beyond len are never accepted, so the FIFO is empty on exit from RUN.
- Write attempted with in_full=1 in RUN: word dropped, overflow set. Writes in IDLE/DONE are ignored and do not set overflow.
- start while busy: ignored.
- Simultaneous push and pop:
  - Permitted when 0<level<DEPTH; level unchanged.
  - At level==DEPTH, in_full is already high, so no push.
  - Write to an empty FIFO is not bypassed (see latency).
- Counters are LEN_W bits and never wrap, because len ≤ 2^LEN_W−1.
- Reset mid-transfer: immediate return to reset values; buffered data is discarded.

## Timing
- Write→output latency: a word accepted at edge n appears on out_valid/out_data after edge n, i.e. registered, one cycle.
- in_full and out_valid are functions of registered state only; no combinational path from out_ready to in_full or from in_wr to out_valid.
- Freeing a slot at edge n deasserts in_full after edge n.
- out_data/out_valid/out_last stay stable while out_valid & ~out_ready.
- Sustained throughput is one beat per cycle when out_ready=1 and in_wr=1 continuously.
- done asserts the cycle after the last-beat handshake; busy deasserts the cycle after done.

## Structure
- Package mdc_stream_pkg holds:
  - state enum {IDLE, RUN, DONE}, 2 bits
  - default DATA_W/DEPTH/LEN_W constants shared with the matching source block
- Sub-module mdc_sync_fifo: DEPTH×DATA_W register FIFO with wr_en/rd_en/level/empty/full, registered output, async active-high reset.
- Top-level mdc_stream_sink holds the FSM, the counters, write gating and the overflow flag.

## Test plan
- Basic: cfg_len=4, start, write 0xA0..0xA3 back-to-back, out_ready=1 → four beats 0xA0..0xA3 each one cycle after its write, out_last only on 0xA3, done one cycle later, busy low after.
- Back-pressure: DEPTH=16, cfg_len=20, out_ready=0 → in_full rises after the 16th write; hold 5 extra writes → overflow=1, level=16; release out_ready → exactly 20 beats once writes resume, no data loss for accepted words.
- Length gating: cfg_len=3, writer drives 5 words → only 3 accepted, in_full=1 after the third, FIFO empty after done.
- Zero length: cfg_len=0, start → done pulses next cycle, no out_valid, in_full stays 1.
- Stall stability: random out_ready toggling, cfg_len=100, incrementing data → out_data stable under stall, 100 beats in order, single out_last on beat 99.
- Reset mid-transfer: assert reset after 7 of 10 beats → all outputs at reset values asynchronously; a new start with cfg_len=2 completes normally.

Source files
------------

// File: rtl/mdc_stream_pkg.sv
// Shared types and default sizes for the MDC stream endpoints.
// Used by mdc_stream_sink and the matching source block.
package mdc_stream_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 16;
  localparam int LEN_W_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mdc_sync_fifo.sv
// Register-based synchronous FIFO, first word always visible on o_rd_data.
// Ports: i_wr_en/i_wr_data push, i_rd_en pop, o_level/o_empty/o_full status.
module mdc_sync_fifo
  import mdc_stream_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     i_wr_en,
  input  logic [DATA_W-1:0]        i_wr_data,
  input  logic                     i_rd_en,
  output logic [DATA_W-1:0]        o_rd_data,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_empty,
  output logic                     o_full
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_level;
  logic              w_push;
  logic              w_pop;

  assign o_empty   = (r_level == '0);
  assign o_full    = (r_level == (AW+1)'(DEPTH));
  assign o_level   = r_level;
  assign o_rd_data = r_mem[r_rd_ptr];
  assign w_push    = i_wr_en & ~o_full;
  assign w_pop     = i_rd_en & ~o_empty;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_wr_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/mdc_stream_sink.sv
// Network data/wr/full sink re-emitting framed valid/ready transfers.
// Ports: in_* network side, out_* stream side, cfg_len/start/busy/done/overflow/level control.
module mdc_stream_sink
  import mdc_stream_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   in_wr,
  output logic                   in_full,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  input  logic [LEN_W-1:0]       cfg_len,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] level
);

  localparam logic [LEN_W-1:0] L_ONE = LEN_W'(1);

  state_e             r_state;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_wr_cnt;
  logic [LEN_W-1:0]   r_rd_cnt;
  logic               r_ovf;
  logic               r_done;
  logic               r_busy;

  logic               w_run;
  logic               w_push;
  logic               w_pop;
  logic               w_empty;
  logic               w_ff_full;
  logic               w_last_cnt;

  assign w_run      = (r_state == RUN);
  // Gate on both FIFO space and the programmed length so no word
  // past the end of the transfer is ever buffered.
  assign in_full    = ~w_run | w_ff_full | (r_wr_cnt == r_len);
  assign w_push     = in_wr & ~in_full;
  assign out_valid  = w_run & ~w_empty;
  assign w_pop      = out_valid & out_ready;
  assign w_last_cnt = (r_rd_cnt == (r_len - L_ONE));
  assign out_last   = out_valid & w_last_cnt;
  assign busy       = r_busy;
  assign done       = r_done;
  assign overflow   = r_ovf;

  mdc_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .i_wr_en   (w_push),
    .i_wr_data (in_data),
    .i_rd_en   (w_pop),
    .o_rd_data (out_data),
    .o_level   (level),
    .o_empty   (w_empty),
    .o_full    (w_ff_full)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_len    <= '0;
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
      r_ovf    <= 1'b0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_busy <= 1'b1;
            if (cfg_len != '0) begin
              r_len    <= cfg_len;
              r_wr_cnt <= '0;
              r_rd_cnt <= '0;
              r_ovf    <= 1'b0;
              r_state  <= RUN;
            end else begin
              r_done  <= 1'b1;
              r_state <= DONE;
            end
          end
        end
        RUN: begin
          if (w_push) r_wr_cnt <= r_wr_cnt + L_ONE;
          if (w_pop) r_rd_cnt <= r_rd_cnt + L_ONE;
          if (in_wr & in_full) r_ovf <= 1'b1;
          if (w_pop & w_last_cnt) begin
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdc_stream_sink.sv
// Randomized self-checking bench for mdc_stream_sink.
// Reference model: queues of accepted and emitted words.
module tb_mdc_stream_sink;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int LW    = 16;
  localparam int LVW   = $clog2(DEPTH) + 1;

  logic           clock = 1'b0;
  logic           reset;
  logic [DW-1:0]  in_data;
  logic           in_wr;
  logic           in_full;
  logic [DW-1:0]  out_data;
  logic           out_valid;
  logic           out_ready;
  logic           out_last;
  logic [LW-1:0]  cfg_len;
  logic           start;
  logic           busy;
  logic           done;
  logic           overflow;
  logic [LVW-1:0] level;

  always #5 clock = ~clock;

  mdc_stream_sink #(
    .DATA_W (DW),
    .DEPTH  (DEPTH),
    .LEN_W  (LW)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_data   (in_data),
    .in_wr     (in_wr),
    .in_full   (in_full),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .cfg_len   (cfg_len),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow),
    .level     (level)
  );

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] acc_q[$];
  logic [DW-1:0] obs_q[$];
  bit            last_q[$];
  int fullx, validx, levelx, stallx, full_tries;
  int snap_level;
  bit timeout, done_ok, snap_ovf;
  bit busy_after, done_after, ovf_after;
  int level_after;

  // One transfer: writer offers base+i words (held until accepted),
  // reader accepts randomly; expected flags come from queue sizes.
  task automatic xfer(input int len, input int offer, input int rdy_pct,
                      input int wr_pct, input int hold,
                      input logic [DW-1:0] base, input int max_cyc);
    int k, offered, lvl;
    logic pv, pr, pl;
    logic [DW-1:0] pd;
    bit fin;
    acc_q.delete(); obs_q.delete(); last_q.delete();
    fullx = 0; validx = 0; levelx = 0; stallx = 0; full_tries = 0;
    timeout = 0; done_ok = 0; snap_level = -1; snap_ovf = 0;
    @(negedge clock);
    cfg_len = LW'(len); start = 1'b1; in_wr = 1'b0; out_ready = 1'b0;
    @(negedge clock);
    start = 1'b0;
    k = 0; offered = 0; pv = 0; pr = 0; pl = 0; pd = '0; fin = 0;
    while (1) begin
      lvl = acc_q.size() - obs_q.size();
      if (in_full !== ((lvl == DEPTH) || (acc_q.size() == len))) fullx++;
      if (out_valid !== (lvl > 0)) validx++;
      if (level !== LVW'(lvl)) levelx++;
      if (pv && !pr &&
          (out_valid !== 1'b1 || out_data !== pd || out_last !== pl))
        stallx++;
      if (hold > 0 && k == hold) begin
        snap_level = int'(level);
        snap_ovf = overflow;
      end
      if (fin) begin
        done_ok = (done === 1'b1);
        break;
      end
      if (k >= max_cyc) begin
        timeout = 1;
        break;
      end
      pv = out_valid; pd = out_data; pl = out_last;
      pr = (k >= hold) && ($urandom_range(99) < rdy_pct);
      out_ready = pr;
      if (offered < offer && $urandom_range(99) < wr_pct) begin
        in_wr = 1'b1;
        in_data = base + DW'(offered);
      end else begin
        in_wr = 1'b0;
      end
      if (pv && pr) begin
        obs_q.push_back(out_data);
        last_q.push_back(out_last);
        if (obs_q.size() == len) fin = 1;
      end
      if (in_wr) begin
        if (!in_full) begin
          acc_q.push_back(in_data);
          offered++;
        end else begin
          full_tries++;
        end
      end
      @(negedge clock);
      k++;
    end
    in_wr = 1'b0; out_ready = 1'b0;
    ovf_after = overflow;
    @(negedge clock);
    busy_after = busy;
    done_after = done;
    level_after = int'(level);
  endtask

  task automatic test_reset();
    reset = 1'b1; in_wr = 0; in_data = '0; out_ready = 0;
    cfg_len = '0; start = 0;
    #12;
    total++; if (in_full !== 1'b1) begin bad++; $display("FAIL reset in_full: got %b want 1", in_full); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
    total++; if (out_last !== 1'b0) begin bad++; $display("FAIL reset out_last: got %b want 0", out_last); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset done: got %b want 0", done); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset overflow: got %b want 0", overflow); end
    total++; if (level !== '0) begin bad++; $display("FAIL reset level: got %0d want 0", level); end
    total++; if (out_data !== '0) begin bad++; $display("FAIL reset out_data: got %h want 0", out_data); end
    @(negedge clock);
    reset = 1'b0;
    in_wr = 1'b1; in_data = 32'h55;
    @(negedge clock);
    in_wr = 1'b0;
    @(negedge clock);
    total++; if (in_full !== 1'b1) begin bad++; $display("FAIL idle in_full: got %b want 1", in_full); end
    total++; if (level !== '0) begin bad++; $display("FAIL idle write level: got %0d want 0", level); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL idle write overflow: got %b want 0", overflow); end
  endtask

  task automatic test_basic();
    xfer(4, 4, 100, 100, 0, 32'hA0, 50);
    total++; if (timeout) begin bad++; $display("FAIL basic timeout: got %0d beats want 4", obs_q.size()); end
    total++; if (obs_q.size() != 4) begin bad++; $display("FAIL basic beats: got %0d want 4", obs_q.size()); end
    for (int i = 0; i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== 32'hA0 + DW'(i)) begin bad++; $display("FAIL basic data[%0d]: got %h want %h", i, obs_q[i], 32'hA0 + DW'(i)); end
      total++;
      if (last_q[i] !== (i == 3)) begin bad++; $display("FAIL basic last[%0d]: got %b want %b", i, last_q[i], i == 3); end
    end
    total++; if (validx != 0) begin bad++; $display("FAIL basic latency: got %0d mismatched cycles want 0", validx); end
    total++; if (fullx != 0) begin bad++; $display("FAIL basic in_full: got %0d mismatched cycles want 0", fullx); end
    total++; if (!done_ok) begin bad++; $display("FAIL basic done: got 0 want 1"); end
    total++; if (busy_after !== 1'b0) begin bad++; $display("FAIL basic busy after: got %b want 0", busy_after); end
    total++; if (done_after !== 1'b0) begin bad++; $display("FAIL basic done width: got %b want 0", done_after); end
  endtask

  task automatic test_zero_len();
    int vseen;
    vseen = 0;
    @(negedge clock);
    cfg_len = '0; start = 1'b1; in_wr = 1'b1; in_data = 32'h77;
    @(negedge clock);
    start = 1'b0;
    vseen += int'(out_valid);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL zero done: got %b want 1", done); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL zero busy: got %b want 1", busy); end
    total++; if (in_full !== 1'b1) begin bad++; $display("FAIL zero in_full: got %b want 1", in_full); end
    @(negedge clock);
    vseen += int'(out_valid);
    in_wr = 1'b0;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL zero done pulse: got %b want 0", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL zero busy end: got %b want 0", busy); end
    total++; if (vseen != 0) begin bad++; $display("FAIL zero out_valid: got %0d want 0", vseen); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL zero overflow: got %b want 0", overflow); end
    total++; if (level !== '0) begin bad++; $display("FAIL zero level: got %0d want 0", level); end
  endtask

  task automatic test_len_gate();
    xfer(3, 5, 100, 100, 0, 32'hC0, 50);
    total++; if (timeout) begin bad++; $display("FAIL gate timeout: got %0d beats want 3", obs_q.size()); end
    total++; if (acc_q.size() != 3) begin bad++; $display("FAIL gate accepted: got %0d want 3", acc_q.size()); end
    total++; if (obs_q.size() != 3) begin bad++; $display("FAIL gate beats: got %0d want 3", obs_q.size()); end
    for (int i = 0; i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== 32'hC0 + DW'(i)) begin bad++; $display("FAIL gate data[%0d]: got %h want %h", i, obs_q[i], 32'hC0 + DW'(i)); end
    end
    total++; if (fullx != 0) begin bad++; $display("FAIL gate in_full: got %0d mismatched cycles want 0", fullx); end
    total++; if (ovf_after !== 1'b1) begin bad++; $display("FAIL gate overflow: got %b want 1", ovf_after); end
    total++; if (level_after != 0) begin bad++; $display("FAIL gate level after: got %0d want 0", level_after); end
    total++; if (!done_ok) begin bad++; $display("FAIL gate done: got 0 want 1"); end
  endtask

  task automatic test_back_pressure();
    int nl;
    xfer(20, 20, 100, 100, 21, 32'h100, 300);
    total++; if (timeout) begin bad++; $display("FAIL bp timeout: got %0d beats want 20", obs_q.size()); end
    total++; if (snap_level != 16) begin bad++; $display("FAIL bp level: got %0d want 16", snap_level); end
    total++; if (snap_ovf !== 1'b1) begin bad++; $display("FAIL bp overflow: got %b want 1", snap_ovf); end
    total++; if (fullx != 0) begin bad++; $display("FAIL bp in_full: got %0d mismatched cycles want 0", fullx); end
    total++; if (levelx != 0) begin bad++; $display("FAIL bp level track: got %0d mismatched cycles want 0", levelx); end
    total++; if (obs_q.size() != 20) begin bad++; $display("FAIL bp beats: got %0d want 20", obs_q.size()); end
    nl = 0;
    for (int i = 0; i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== 32'h100 + DW'(i)) begin bad++; $display("FAIL bp data[%0d]: got %h want %h", i, obs_q[i], 32'h100 + DW'(i)); end
      nl += int'(last_q[i]);
    end
    total++; if (nl != 1 || last_q[$] !== 1'b1) begin bad++; $display("FAIL bp last: got %0d lasts want 1 on final", nl); end
    total++; if (!done_ok) begin bad++; $display("FAIL bp done: got 0 want 1"); end
  endtask

  task automatic test_stall();
    int nl, bad_data;
    xfer(100, 100, 50, 70, 0, 32'h1000, 3000);
    total++; if (timeout) begin bad++; $display("FAIL stall timeout: got %0d beats want 100", obs_q.size()); end
    total++; if (stallx != 0) begin bad++; $display("FAIL stall stability: got %0d unstable cycles want 0", stallx); end
    total++; if (validx != 0) begin bad++; $display("FAIL stall valid: got %0d mismatched cycles want 0", validx); end
    total++; if (fullx != 0) begin bad++; $display("FAIL stall in_full: got %0d mismatched cycles want 0", fullx); end
    total++; if (levelx != 0) begin bad++; $display("FAIL stall level: got %0d mismatched cycles want 0", levelx); end
    total++; if (obs_q.size() != 100) begin bad++; $display("FAIL stall beats: got %0d want 100", obs_q.size()); end
    nl = 0; bad_data = 0;
    for (int i = 0; i < obs_q.size(); i++) begin
      if (obs_q[i] !== 32'h1000 + DW'(i)) bad_data++;
      nl += int'(last_q[i]);
    end
    total++; if (bad_data != 0) begin bad++; $display("FAIL stall order: got %0d wrong words want 0", bad_data); end
    total++; if (nl != 1 || last_q[$] !== 1'b1) begin bad++; $display("FAIL stall last: got %0d lasts want 1 on beat 99", nl); end
    total++; if (ovf_after !== (full_tries > 0)) begin bad++; $display("FAIL stall overflow: got %b want %b", ovf_after, full_tries > 0); end
    total++; if (!done_ok) begin bad++; $display("FAIL stall done: got 0 want 1"); end
    total++; if (busy_after !== 1'b0) begin bad++; $display("FAIL stall busy after: got %b want 0", busy_after); end
  endtask

  task automatic test_reset_mid();
    int beats, w;
    logic pv;
    @(negedge clock);
    cfg_len = 16'd10; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    beats = 0; w = 0;
    for (int k = 0; k < 60 && beats < 7; k++) begin
      out_ready = 1'b1; in_wr = 1'b1; in_data = 32'hD0 + DW'(w);
      pv = out_valid;
      if (!in_full) w++;
      @(negedge clock);
      if (pv) beats++;
    end
    total++; if (beats != 7) begin bad++; $display("FAIL mid beats: got %0d want 7", beats); end
    #2 reset = 1'b1;
    #1;
    total++; if (in_full !== 1'b1) begin bad++; $display("FAIL mid in_full: got %b want 1", in_full); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid out_valid: got %b want 0", out_valid); end
    total++; if (out_last !== 1'b0) begin bad++; $display("FAIL mid out_last: got %b want 0", out_last); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL mid done: got %b want 0", done); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL mid overflow: got %b want 0", overflow); end
    total++; if (level !== '0) begin bad++; $display("FAIL mid level: got %0d want 0", level); end
    total++; if (out_data !== '0) begin bad++; $display("FAIL mid out_data: got %h want 0", out_data); end
    in_wr = 1'b0; out_ready = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    xfer(2, 2, 100, 100, 0, 32'hE0, 40);
    total++; if (timeout) begin bad++; $display("FAIL mid restart timeout: got %0d beats want 2", obs_q.size()); end
    total++; if (obs_q.size() != 2) begin bad++; $display("FAIL mid restart beats: got %0d want 2", obs_q.size()); end
    for (int i = 0; i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== 32'hE0 + DW'(i) || last_q[i] !== (i == 1)) begin bad++; $display("FAIL mid restart beat[%0d]: got %h/%b want %h/%b", i, obs_q[i], last_q[i], 32'hE0 + DW'(i), i == 1); end
    end
    total++; if (!done_ok) begin bad++; $display("FAIL mid restart done: got 0 want 1"); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_len_gate();
    test_back_pressure();
    test_stall();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
